// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request/operand/result signal bundle for alu_issue_ctrl
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [5:0]       opSignal;
    logic [WIDTH-1:0] shiftResult;
    logic [WIDTH-1:0] aluResult;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dataOut;

    // Requester / execution-unit side
    modport master (
        output in_valid, dataA, dataB, Signal, shiftResult, aluResult, out_ready,
        input  in_ready, opA, opB, opSignal, out_valid, dataOut
    );

    // Issue controller side
    modport slave (
        input  in_valid, dataA, dataB, Signal, shiftResult, aluResult, out_ready,
        output in_ready, opA, opB, opSignal, out_valid, dataOut
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU issue sequencer with HI/LO and shift-add MULTU (optional: ALU_MUL_EN)
module alu_issue_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_issue_ctrl_if.slave bus
);
    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;
`ifdef ALU_MUL_EN
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam int         CNT_W   = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);
`endif

    if (WIDTH != 32 || MUL_CYCLES != WIDTH) begin : g_param_check
        $error("alu_issue_ctrl supports only WIDTH=32 and MUL_CYCLES=WIDTH");
    end

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [5:0]       op_sig_q, op_sig_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] exec_result;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    // Select the single-cycle result from the registered function code
    always_comb begin
        exec_result = '0;
        case (op_sig_q)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT: exec_result = bus.aluResult;
            F_SLL:                            exec_result = bus.shiftResult;
`ifdef ALU_MUL_EN
            F_MFHI:                           exec_result = hi_q;
            F_MFLO:                           exec_result = lo_q;
`endif
            default:                          exec_result = '0;
        endcase
    end

    // State register and datapath registers; reset aborts any operation and clears HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_sig_q   <= '0;
            data_out_q <= '0;
`ifdef ALU_MUL_EN
            hi_q       <= '0;
            lo_q       <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_sig_q   <= op_sig_d;
            data_out_q <= data_out_d;
`ifdef ALU_MUL_EN
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Next-state logic: issue, single-cycle execute, shift-add multiply, result hold
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_sig_d   = op_sig_q;
        data_out_d = data_out_q;
`ifdef ALU_MUL_EN
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_a_d   = bus.dataA;
                    op_b_d   = bus.dataB;
                    op_sig_d = bus.Signal;
                    state_d  = EXEC;
`ifdef ALU_MUL_EN
                    if (bus.Signal == F_MULTU) begin
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, bus.dataA};
                        cnt_d   = '0;
                        state_d = MUL;
                    end
`endif
                end
            end
            EXEC: begin
                data_out_d = exec_result;
                state_d    = DONE;
            end
`ifdef ALU_MUL_EN
            // mcand_q always holds opA << cnt_q, so one add per multiplier bit
            MUL: begin
                if (op_b_q[cnt_q]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    hi_d       = acc_d[2*WIDTH-1:WIDTH];
                    lo_d       = acc_d[WIDTH-1:0];
                    data_out_d = acc_d[WIDTH-1:0];
                    state_d    = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = reset && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.opA       = op_a_q;
    assign bus.opB       = op_b_q;
    assign bus.opSignal  = op_sig_q;
    assign bus.dataOut   = data_out_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - table-driven and randomized checks of alu_issue_ctrl
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(32)) bus ();

    alu_issue_ctrl #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural Shifter and ALU core hanging off the operand bus
    function automatic logic [31:0] alu_core(input logic [31:0] a, input logic [31:0] b, input logic [5:0] s);
        case (s)
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign bus.shiftResult = bus.opA << bus.opB[4:0];
    assign bus.aluResult   = alu_core(bus.opA, bus.opB, bus.opSignal);

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: result and latency from the function-code rules, HI/LO as a 64-bit product
    task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] s,
                             output logic [31:0] exp_d, output int exp_lat);
        logic [63:0] prod;
        exp_lat = 1;
        case (s)
            6'd0:                         exp_d = a << b[4:0];
            6'd32, 6'd34, 6'd36, 6'd37, 6'd42: exp_d = alu_core(a, b, s);
            6'd25: if (MUL_EN) begin
                       prod = 64'(a) * 64'(b);
                       m_hi = prod[63:32];
                       m_lo = prod[31:0];
                       exp_d = m_lo;
                       exp_lat = 32;
                   end else exp_d = '0;
            6'd16:   exp_d = MUL_EN ? m_hi : 32'd0;
            6'd18:   exp_d = MUL_EN ? m_lo : 32'd0;
            default: exp_d = '0;
        endcase
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] s, input int bp, input logic [31:0] exp_d, input int exp_lat);
        int w;
        int lat;
        logic [31:0] held;
        @(negedge clk);
        bus.dataA = a; bus.dataB = b; bus.Signal = s; bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
        check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dataA = $urandom; bus.dataB = $urandom; bus.Signal = 6'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " dataOut"}, bus.dataOut, exp_d);
        check({name, " opA held"}, bus.opA, a);
        held = bus.dataOut;
        repeat (bp) begin
            @(negedge clk);
            check({name, " bp out_valid"}, 32'(bus.out_valid), 32'd1);
            check({name, " bp dataOut"}, bus.dataOut, held);
            check({name, " bp in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        check({name, " in_ready back"}, 32'(bus.in_ready), 32'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  sig;
        int          bp;
        logic [31:0] exp_d;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];
    logic [5:0] codes[11] = '{6'd0, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd25, 6'd16, 6'd18, 6'd63, 6'd1};

    initial begin
        logic [31:0] e_d;
        int          e_lat;
        logic [31:0] ra, rb;
        logic [5:0]  rs;

        tbl.push_back('{32'h0000_0001, 32'd31,         6'd0,  0, 32'h8000_0000, 1});
        tbl.push_back('{32'h0000_0001, 32'h0000_0025,  6'd0,  0, 32'h0000_0020, 1});
        tbl.push_back('{32'd5,         32'd7,          6'd32, 4, 32'd12,        1});
        tbl.push_back('{32'd3,         32'd10,         6'd34, 0, 32'hFFFF_FFF9, 1});
        tbl.push_back('{32'hF0F0_1234, 32'h0FF0_FFFF,  6'd36, 1, 32'h00F0_1234, 1});
        tbl.push_back('{32'hF000_0000, 32'h0000_000F,  6'd37, 0, 32'hF000_000F, 1});
        tbl.push_back('{32'hFFFF_FFFF, 32'd1,          6'd42, 0, 32'd1,         1});
        if (MUL_EN) begin
            tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd25, 2, 32'h0000_0001, 32});
            tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd63, 0, 32'd0,         1});
            tbl.push_back('{32'd0,         32'd0,         6'd16, 0, 32'hFFFF_FFFE, 1});
            tbl.push_back('{32'd0,         32'd0,         6'd18, 0, 32'h0000_0001, 1});
        end else begin
            tbl.push_back('{32'd3,         32'd4,         6'd25, 0, 32'd0, 1});
            tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd63, 0, 32'd0, 1});
            tbl.push_back('{32'd0,         32'd0,         6'd16, 0, 32'd0, 1});
            tbl.push_back('{32'd0,         32'd0,         6'd18, 0, 32'd0, 1});
        end

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.dataA = '0; bus.dataB = '0; bus.Signal = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready",  32'(bus.in_ready),  32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset dataOut",   bus.dataOut,        32'd0);
        check("reset opA",       bus.opA,            32'd0);
        check("reset opSignal",  32'(bus.opSignal),  32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            ref_model(tbl[i].a, tbl[i].b, tbl[i].sig, e_d, e_lat);
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sig, tbl[i].bp,
                   tbl[i].exp_d, tbl[i].exp_lat);
        end

        // Reset in the middle of MULTU 3x4
        @(negedge clk);
        bus.dataA = 32'd3; bus.dataB = 32'd4; bus.Signal = 6'd25; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst in_ready",  32'(bus.in_ready),  32'd0);
        check("midrst dataOut",   bus.dataOut,        32'd0);
        check("midrst opA",       bus.opA,            32'd0);
        check("midrst opB",       bus.opB,            32'd0);
        check("midrst opSignal",  32'(bus.opSignal),  32'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("postrst in_ready", 32'(bus.in_ready), 32'd1);
        run_op("postrst MFLO", 32'd0, 32'd0, 6'd18, 0, 32'd0, 1);
        run_op("postrst MFHI", 32'd0, 32'd0, 6'd16, 0, 32'd0, 1);

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = codes[$urandom_range(0, 10)];
            if ($urandom_range(0, 7) == 0) rs = 6'($urandom);
            ref_model(ra, rb, rs, e_d, e_lat);
            run_op($sformatf("rnd%0d sig%0d", i, rs), ra, rb, rs, $urandom_range(0, 3), e_d, e_lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
